// File: rtl/aemb2_wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant state
// encoding, round-robin owner tags and the default timeout counter width.
package aemb2_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    // Identity of the most recently granted master.
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    // Default width of the stalled-strobe watchdog counter.
    localparam int AEMB_TMO_DEF = 8;

endpackage

// File: rtl/aemb2_wb_arbiter_tmo.sv
// Stalled-strobe watchdog for the shared port. Counts cycles of an
// outstanding strobe; at all-ones without an ack it fires a one-cycle hit
// that the top turns into a fake ack, and latches a sticky error flag.
// Only instantiated when AEMB2_ARB_TIMEOUT_EN is defined.
module aemb2_arb_tmo #(
    parameter int AEMB_TMO = 8
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    input  logic stb_i,
    input  logic ack_i,
    output logic hit_o,
    output logic err_o
);

    logic [AEMB_TMO-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;

    assign hit_o = stb_i & ~ack_i & (cnt_q == {AEMB_TMO{1'b1}});
    assign err_o = err_q;

    // Counter restarts whenever the strobe is idle, acked or forcibly ended.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        err_d = err_q | hit_o;
        if (!stb_i || ack_i || hit_o) begin
            cnt_d = '0;
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/aemb2_wb_arbiter.sv
// Two-master Wishbone arbiter sharing one memory port between the fetch
// bus (iwb) and the data bus (dwb). A grant is held until the owner drops
// cyc; contention is settled round-robin. Defining AEMB2_ARB_TIMEOUT_EN adds
// a watchdog that terminates strobes the slave never acks.
module aemb2_wb_arbiter
    import aemb2_wb_arbiter_pkg::*;
#(
    parameter int AEMB_AWB = 32
`ifdef AEMB2_ARB_TIMEOUT_EN
    ,
    parameter int AEMB_TMO = AEMB_TMO_DEF
`endif
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_i,
    input  logic [AEMB_AWB-1:2] iwb_adr_i,
    input  logic                iwb_stb_i,
    input  logic                iwb_cyc_i,
    input  logic [3:0]          iwb_sel_i,
    input  logic                iwb_wre_i,
    output logic [31:0]         iwb_dat_o,
    output logic                iwb_ack_o,
    input  logic [AEMB_AWB-1:2] dwb_adr_i,
    input  logic [31:0]         dwb_dat_i,
    input  logic [3:0]          dwb_sel_i,
    input  logic                dwb_stb_i,
    input  logic                dwb_cyc_i,
    input  logic                dwb_wre_i,
    input  logic                dwb_tag_i,
    output logic [31:0]         dwb_dat_o,
    output logic                dwb_ack_o,
    output logic [AEMB_AWB-1:2] mwb_adr_o,
    output logic [31:0]         mwb_dat_o,
    output logic [3:0]          mwb_sel_o,
    output logic                mwb_stb_o,
    output logic                mwb_cyc_o,
    output logic                mwb_wre_o,
    output logic                mwb_tag_o,
    input  logic [31:0]         mwb_dat_i,
    input  logic                mwb_ack_i,
    output logic                arb_err_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       stb_raw;
    logic       tmo_hit;
    logic       ack_any;
    logic [31:0] rd_dat;

    // Grant decision: dwb wins a tie unless it was the last owner.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (dwb_cyc_i && (!iwb_cyc_i || last_q == LAST_I)) begin
                    state_d = GNT_D;
                end else if (iwb_cyc_i) begin
                    state_d = GNT_I;
                end
            end
            GNT_I: begin
                if (!iwb_cyc_i) begin
                    state_d = IDLE;
                    last_d  = LAST_I;
                end
            end
            GNT_D: begin
                if (!dwb_cyc_i) begin
                    state_d = IDLE;
                    last_d  = LAST_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant state and round-robin history.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q <= IDLE;
            last_q  <= LAST_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Shared-port mux; idle drives everything low. iwb has no write data or tag.
    always_comb begin
        mwb_adr_o = '0;
        mwb_dat_o = '0;
        mwb_sel_o = '0;
        mwb_wre_o = 1'b0;
        mwb_tag_o = 1'b0;
        mwb_cyc_o = 1'b0;
        stb_raw   = 1'b0;
        case (state_q)
            GNT_I: begin
                mwb_adr_o = iwb_adr_i;
                mwb_sel_o = iwb_sel_i;
                mwb_wre_o = iwb_wre_i;
                mwb_cyc_o = iwb_cyc_i;
                stb_raw   = iwb_stb_i;
            end
            GNT_D: begin
                mwb_adr_o = dwb_adr_i;
                mwb_dat_o = dwb_dat_i;
                mwb_sel_o = dwb_sel_i;
                mwb_wre_o = dwb_wre_i;
                mwb_tag_o = dwb_tag_i;
                mwb_cyc_o = dwb_cyc_i;
                stb_raw   = dwb_stb_i;
            end
            default: ;
        endcase
    end

`ifdef AEMB2_ARB_TIMEOUT_EN
    aemb2_arb_tmo #(
        .AEMB_TMO (AEMB_TMO)
    ) u_tmo (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .stb_i     (stb_raw),
        .ack_i     (mwb_ack_i),
        .hit_o     (tmo_hit),
        .err_o     (arb_err_o)
    );
`else
    assign tmo_hit   = 1'b0;
    assign arb_err_o = 1'b0;
`endif

    // A watchdog hit ends the strobe locally and returns zero data.
    assign mwb_stb_o = stb_raw & ~tmo_hit;
    assign ack_any   = mwb_ack_i | tmo_hit;
    assign rd_dat    = tmo_hit ? 32'd0 : mwb_dat_i;
    assign iwb_dat_o = rd_dat;
    assign dwb_dat_o = rd_dat;
    assign iwb_ack_o = ack_any & (state_q == GNT_I);
    assign dwb_ack_o = ack_any & (state_q == GNT_D);

endmodule

// File: doc/aemb2_wb_arbiter.md
# aemb2_wb_arbiter

Two-master Wishbone arbiter that shares one external memory port between the core's instruction fetch bus (iwb) and data bus (dwb). It sits between the core top level and a single unified-memory slave. It grants the port to one master per bus cycle and holds the grant until that master drops `cyc`. It routes the slave's `ack`/`dat` only to the granted master.

## Interface
- `AEMB_AWB`, 32, address width; address buses are `[AEMB_AWB-1:2]`.
- `AEMB_TMO`, 8, timeout counter width; used only with `AEMB2_ARB_TIMEOUT_EN`.

- `sys_clk_i`  in  1  sole clock, rising edge.
- `sys_rst_i`  in  1  reset; asynchronous, active-high.
- `iwb_adr_i`  in  AEMB_AWB-2  fetch address.
- `iwb_stb_i`, `iwb_cyc_i`  in  1  fetch strobe and cycle.
- `iwb_sel_i`  in  4  fetch byte select.
- `iwb_wre_i`  in  1  fetch write enable (normally 0).
- `iwb_dat_o`  out  32  fetch read data.
- `iwb_ack_o`  out  1  fetch acknowledge.
- `dwb_adr_i`  in  AEMB_AWB-2  data address.
- `dwb_dat_i`  in  32  data write data.
- `dwb_sel_i`  in  4  data byte select.
- `dwb_stb_i`, `dwb_cyc_i`, `dwb_wre_i`, `dwb_tag_i`  in  1  data strobe, cycle, write enable, tag.
- `dwb_dat_o`  out  32  data read data.
- `dwb_ack_o`  out  1  data acknowledge.
- `mwb_adr_o`  out  AEMB_AWB-2  shared-port address.
- `mwb_dat_o`  out  32  shared-port write data.
- `mwb_sel_o`  out  4  shared-port byte select.
- `mwb_stb_o`, `mwb_cyc_o`, `mwb_wre_o`, `mwb_tag_o`  out  1  shared-port strobe, cycle, write enable, tag.
- `mwb_dat_i`  in  32  shared-port read data.
- `mwb_ack_i`  in  1  shared-port acknowledge.
- `arb_err_o`  out  1  sticky timeout flag; tied 0 when the timeout feature is compiled out.

## Operation
- States: IDLE, GNT_I, GNT_D. The state is registered.
- IDLE → GNT_D when `dwb_cyc_i` is high and either `iwb_cyc_i` is low or `last` = I.
- IDLE → GNT_I when `iwb_cyc_i` is high and either `dwb_cyc_i` is low or `last` = D.
- `last` records the most recently granted master. Contention is therefore round-robin.
- GNT_x → IDLE when the owner's `cyc` is low. `last` ← x on that transition.
- There is no preemption: the owner keeps the port for any number of back-to-back strobes while its `cyc` stays high.
- Muxing is combinational from state:
  - `mwb_adr/dat/sel/wre/tag_o` carry the owner's signals.
  - `mwb_stb_o` = owner `stb`; `mwb_cyc_o` = owner `cyc`.
  - In IDLE: `stb`/`cyc`/`wre` = 0; address, data and tag are don't-care but driven 0.
  - `iwb` has no tag input; `mwb_tag_o` = 0 when GNT_I.
- `iwb_dat_o` = `dwb_dat_o` = `mwb_dat_i` (broadcast).
- `iwb_ack_o` = `mwb_ack_i` & GNT_I; `dwb_ack_o` = `mwb_ack_i` & GNT_D.
- A non-owner never sees `ack`.
- Reset: state IDLE, `last` = I (so dwb wins the first contention), `arb_err_o` = 0. All strobe, cycle and ack outputs are 0. Reset may assert mid-cycle; the slave must tolerate the abandoned strobe.

## Timing
- Grant latency is 1 cycle: a request in IDLE at edge n gives `mwb_stb_o` high after edge n+1.
- Release: owner `cyc` low at edge n → IDLE after n+1 → next grant after n+2. There is one dead cycle between owners.
- `ack` passes through combinationally with zero added latency. A slave acking in the first strobe cycle completes in 1 cycle.
- Simultaneous owner release and other-master request is handled by the normal IDLE decision one cycle later.

## Configuration
- `AEMB2_ARB_TIMEOUT_EN` defined:
  - A `AEMB_TMO`-bit counter clears on reset, on `mwb_ack_i`, and whenever `mwb_stb_o` is 0. It otherwise increments.
  - When it reaches all-ones with no ack, the arbiter pulses the owner's `ack_o` for one cycle with read data 0, forces `mwb_stb_o` low that cycle, and sets `arb_err_o` (sticky until reset).
- Undefined: no counter; `arb_err_o` = 0; a slave that never acks stalls the port indefinitely.

## Structure
- Shared package: state encoding constants (IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2) and the `AEMB_TMO` default.
- One sub-module: `aemb2_arb_tmo` (timeout counter and error flag), instantiated only under `AEMB2_ARB_TIMEOUT_EN`.

## Test plan
- Reset asserted mid-transfer → all `stb`/`cyc`/`ack` outputs 0 and state IDLE immediately, asynchronously.
- Only iwb requests at address 0x100; slave acks 1 cycle later with 0xDEADBEEF → `mwb_adr_o` = 0x40 (word), `iwb_ack_o` pulses with `iwb_dat_o` = 0xDEADBEEF, `dwb_ack_o` stays 0.
- iwb and dwb request in the same cycle after reset → dwb granted first; after dwb drops `cyc`, iwb is granted 2 cycles later.
- Both masters continuously request single-strobe cycles → grants alternate D, I, D, I; neither master starves.
- dwb holds `cyc` for 4 back-to-back strobes while iwb requests → all 4 complete on dwb before iwb is granted.
- With `AEMB2_ARB_TIMEOUT_EN` and `AEMB_TMO` = 4: slave never acks a dwb read → after 15 stalled cycles `dwb_ack_o` pulses with data 0 and `arb_err_o` = 1 until reset.
